// File: rtl/shift_sequencer.sv
// Command sequencer for a 4-bit universal shift register: runs LOAD/PUSH/CYCLE for N cycles, then pulses DONE.
// Optional feature: define SEQ_ABORT_EN to let ABORT end an in-progress run early.
module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic             CMD_SIN,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_STEPS,
  input  logic             ABORT,
  output logic             ENB,
  output logic [1:0]       MODO,
  output logic             DIR,
  output logic             S_IN,
  output logic [WIDTH-1:0] D,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam logic [1:0] MODO_LOAD  = 2'b00;
  localparam logic [1:0] MODO_PUSH  = 2'b01;
  localparam logic [1:0] MODO_CYCLE = 2'b10;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SHIFT  = 2'b01;
  localparam logic [1:0] OP_ROTATE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_op, w_op_nxt;
  logic               r_enb, w_enb_nxt;
  logic [1:0]         r_modo, w_modo_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_sin, w_sin_nxt;
  logic [WIDTH-1:0]   r_d, w_d_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic               w_abort;

`ifdef SEQ_ABORT_EN
  assign w_abort = ABORT;
`else
  assign w_abort = ABORT & 1'b0;
`endif

  function automatic logic [1:0] modo_of(input logic [1:0] op);
    case (op)
      OP_SHIFT:  modo_of = MODO_PUSH;
      OP_ROTATE: modo_of = MODO_CYCLE;
      default:   modo_of = MODO_LOAD;
    endcase
  endfunction

  // Next state plus next values of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_enb_nxt   = 1'b0;
    w_modo_nxt  = MODO_LOAD;
    w_dir_nxt   = r_dir;
    w_sin_nxt   = r_sin;
    w_d_nxt     = r_d;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CMD_VALID) begin
          w_op_nxt   = CMD_OP;
          w_cnt_nxt  = CMD_STEPS;
          w_busy_nxt = 1'b1;
          if (CMD_OP == OP_LOAD ||
              (CMD_OP != OP_RSVD && CMD_STEPS != CNT_W'(0))) begin
            w_state_nxt = S_EXEC;
            w_enb_nxt   = 1'b1;
            w_modo_nxt  = modo_of(CMD_OP);
            w_dir_nxt   = CMD_DIR;
            w_sin_nxt   = CMD_SIN;
            w_d_nxt     = CMD_DATA;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = (CMD_OP == OP_RSVD);
          end
        end
      end
      S_EXEC: begin
        w_busy_nxt = 1'b1;
        if (w_abort || r_op == OP_LOAD || r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = w_abort;
        end else begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          w_enb_nxt  = 1'b1;
          w_modo_nxt = modo_of(r_op);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_LOAD;
      r_enb   <= 1'b0;
      r_modo  <= MODO_LOAD;
      r_dir   <= 1'b0;
      r_sin   <= 1'b0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_enb   <= w_enb_nxt;
      r_modo  <= w_modo_nxt;
      r_dir   <= w_dir_nxt;
      r_sin   <= w_sin_nxt;
      r_d     <= w_d_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign CMD_READY = (r_state == S_IDLE);
  assign ENB       = r_enb;
  assign MODO      = r_modo;
  assign DIR       = r_dir;
  assign S_IN      = r_sin;
  assign D         = r_d;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 4-bit universal shift register on its outputs.
module tb_shift_sequencer;

  localparam logic [1:0] M_LOAD  = 2'b00;
  localparam logic [1:0] M_PUSH  = 2'b01;
  localparam logic [1:0] M_CYCLE = 2'b10;

`ifdef SEQ_ABORT_EN
  localparam int   ABT_ENB = 2;
  localparam logic ABT_ERR = 1'b1;
`else
  localparam int   ABT_ENB = 6;
  localparam logic ABT_ERR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic       CMD_DIR = 1'b0;
  logic       CMD_SIN = 1'b0;
  logic [3:0] CMD_DATA = 4'h0;
  logic [3:0] CMD_STEPS = 4'h0;
  logic       ABORT = 1'b0;
  logic       ENB;
  logic [1:0] MODO;
  logic       DIR;
  logic       S_IN;
  logic [3:0] D;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int errors = 0;
  int checks = 0;
  logic [3:0] q = 4'h0;

  shift_sequencer #(.WIDTH(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET_L(RESET_L),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_SIN(CMD_SIN),
    .CMD_DATA(CMD_DATA), .CMD_STEPS(CMD_STEPS), .ABORT(ABORT),
    .ENB(ENB), .MODO(MODO), .DIR(DIR), .S_IN(S_IN), .D(D),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Shift register being sequenced
  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        M_LOAD:  q <= D;
        M_PUSH:  q <= DIR ? {S_IN, q[3:1]} : {q[2:0], S_IN};
        M_CYCLE: q <= DIR ? {q[0], q[3:1]} : {q[2:0], q[3]};
        default: q <= q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic dir,
                         input logic sin, input logic [3:0] data, input logic [3:0] steps,
                         input int exp_enb, input logic exp_err, input logic [1:0] exp_modo,
                         input int abort_at);
    int   enb_cnt = 0;
    int   done_at = 0;
    logic err_seen = 1'b0;
    @(negedge CLK);
    check({tag, " ready_before"}, CMD_READY, 1);
    CMD_OP = op; CMD_DIR = dir; CMD_SIN = sin; CMD_DATA = data; CMD_STEPS = steps;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_OP = 2'b11; CMD_DIR = ~dir; CMD_SIN = ~sin; CMD_DATA = ~data; CMD_STEPS = 4'd1;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge CLK);
      ABORT = (k == abort_at);
      check({tag, " busy"}, BUSY, 1);
      check({tag, " ready_low"}, CMD_READY, 0);
      if (ENB) begin
        enb_cnt++;
        check({tag, " modo"}, MODO, exp_modo);
        check({tag, " dir"}, DIR, dir);
        check({tag, " d"}, D, data);
      end
      if (DONE) begin
        done_at  = k;
        err_seen = ERR;
      end
    end
    ABORT = 1'b0;
    check({tag, " enb_cycles"}, enb_cnt, exp_enb);
    check({tag, " done_cycle"}, done_at, exp_enb + 1);
    check({tag, " err"}, err_seen, exp_err);
    @(negedge CLK);
    check({tag, " ready_after"}, CMD_READY, 1);
    check({tag, " done_after"}, DONE, 0);
    check({tag, " busy_after"}, BUSY, 0);
    check({tag, " enb_after"}, ENB, 0);
    check({tag, " modo_after"}, MODO, M_LOAD);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst ready", CMD_READY, 1);
    check("rst enb", ENB, 0);
    check("rst modo", MODO, M_LOAD);
    check("rst dir", DIR, 0);
    check("rst sin", S_IN, 0);
    check("rst d", D, 0);
    check("rst busy", BUSY, 0);
    check("rst done", DONE, 0);
    check("rst err", ERR, 0);
    RESET_L = 1'b1;

    run_cmd("load", 2'b00, 1'b0, 1'b0, 4'b1101, 4'd0, 1, 1'b0, M_LOAD, 0);
    check("load reg", q, 4'b1101);

    run_cmd("shl3", 2'b01, 1'b0, 1'b0, 4'h5, 4'd3, 3, 1'b0, M_PUSH, 0);
    check("shl3 reg", q, 4'b1000);

    run_cmd("ror15", 2'b10, 1'b1, 1'b0, 4'h3, 4'd15, 15, 1'b0, M_CYCLE, 0);
    check("ror15 reg", q, 4'b0001);

    run_cmd("steps0", 2'b01, 1'b1, 1'b1, 4'hA, 4'd0, 0, 1'b0, M_PUSH, 0);
    check("steps0 d_hold", D, 4'h3);
    run_cmd("rsvd", 2'b11, 1'b0, 1'b0, 4'h6, 4'd4, 0, 1'b1, M_LOAD, 0);
    check("rsvd reg", q, 4'b0001);

    run_cmd("abort", 2'b01, 1'b1, 1'b1, 4'h9, 4'd6, ABT_ENB, ABT_ERR, M_PUSH, 2);

    // Reset two cycles into a 6-step run
    @(negedge CLK);
    CMD_OP = 2'b01; CMD_DIR = 1'b0; CMD_SIN = 1'b1; CMD_DATA = 4'h7; CMD_STEPS = 4'd6;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    check("midrst enb_pre", ENB, 1);
    RESET_L = 1'b0;
    #1;
    check("midrst enb", ENB, 0);
    check("midrst busy", BUSY, 0);
    check("midrst ready", CMD_READY, 1);
    check("midrst modo", MODO, M_LOAD);
    check("midrst d", D, 0);
    check("midrst dir", DIR, 0);
    check("midrst sin", S_IN, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("midrst no_done", DONE, 0);
    end
    RESET_L = 1'b1;
    run_cmd("postrst", 2'b00, 1'b0, 1'b0, 4'b0110, 4'd0, 1, 1'b0, M_LOAD, 0);
    check("postrst reg", q, 4'b0110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
